// File: rtl/sat_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sat_accum_seq (with helper sat_cla_add16)
//  Description : Multi-cycle saturating accumulate sequencer. Streams a
//                programmed number of signed 16-bit operands through a
//                saturating carry-lookahead adder into an accumulator, then
//                reports final sum, sticky overflow and N/Z flags.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                start, len        - job request and operand count (IDLE only)
//                abort             - cancel job (ACCUM only)
//                in_valid/in_ready - operand handshake
//                in_data, in_sub   - operand and add/subtract select
//                acc_out           - accumulator register
//                busy, done        - job in progress / one-cycle completion
//                ovfl_sticky       - OR of adder overflow over the job
//                flag_n, flag_z    - sign / zero of result, valid after done
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  sat_cla_add16 : 16-bit two's complement saturating adder/subtractor built
//  from four 4-bit carry-lookahead groups with a lookahead carry across them.
// ----------------------------------------------------------------------------
module sat_cla_add16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_sub,
   output logic [15:0] o_s,
   output logic        o_ovfl
);
   logic [15:0] w_b;
   logic [15:0] w_g;
   logic [15:0] w_p;
   logic [16:0] w_c;
   logic [3:0]  w_gg;
   logic [3:0]  w_gp;
   logic [15:0] w_sum;

   // Subtraction is A + ~B + 1; the +1 enters as the carry-in.
   assign w_b = i_sub ? ~i_b : i_b;
   assign w_g = i_a & w_b;
   assign w_p = i_a ^ w_b;

   always_comb begin
      w_gg = '0;
      w_gp = '0;
      w_c  = '0;
      for (int k = 0; k < 4; k++) begin
         w_gp[k] = &w_p[4*k +: 4];
         w_gg[k] = w_g[4*k+3]
                 | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
      end
      // Group-level lookahead carries
      w_c[0]  = i_sub;
      w_c[4]  = w_gg[0] | (w_gp[0] & w_c[0]);
      w_c[8]  = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & w_c[0]);
      w_c[12] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0])
              | (&w_gp[2:0] & w_c[0]);
      w_c[16] = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1])
              | (&w_gp[3:1] & w_gg[0]) | (&w_gp[3:0] & w_c[0]);
      // Carries inside each group
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 3; j++) begin
            w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
         end
      end
   end

   assign w_sum  = w_p ^ w_c[15:0];
   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign o_ovfl = w_c[16] ^ w_c[15];
   // On overflow both effective operands share A's sign, so A picks the rail.
   assign o_s    = o_ovfl ? (i_a[15] ? 16'h8000 : 16'h7FFF) : w_sum;
endmodule

// ----------------------------------------------------------------------------
//  sat_accum_seq : job sequencer around the saturating adder.
// ----------------------------------------------------------------------------
module sat_accum_seq #(
   parameter int unsigned LEN_W          = 4,
   parameter bit          CLEAR_ON_START = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   input  logic             in_sub,
   output logic             in_ready,
   output logic [15:0]      acc_out,
   output logic             busy,
   output logic             done,
   output logic             ovfl_sticky,
   output logic             flag_n,
   output logic             flag_z
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] c_CNT_ONE = LEN_W'(1);

   state_t           r_state;
   logic [LEN_W-1:0] r_cnt;
   logic [15:0]      r_acc;
   logic             r_busy;
   logic             r_done;
   logic             r_ovfl;
   logic             r_flag_n;
   logic             r_flag_z;

   logic             w_in_ready;
   logic [15:0]      w_sum;
   logic             w_ovfl;

   sat_cla_add16 u_add (
      .i_a    (r_acc),
      .i_b    (in_data),
      .i_sub  (in_sub),
      .o_s    (w_sum),
      .o_ovfl (w_ovfl)
   );

   // Abort blocks acceptance in the same cycle it is raised.
   assign w_in_ready = (r_state == ST_ACCUM) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovfl   <= 1'b0;
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_ovfl <= 1'b0;
                  r_cnt  <= len;
                  r_busy <= 1'b1;
                  if (CLEAR_ON_START) begin
                     r_acc <= '0;
                  end
                  if (len != '0) begin
                     r_state <= ST_ACCUM;
                  end else begin
                     // Empty job completes immediately
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_ACCUM: begin
               if (abort) begin
                  // Partial result and sticky overflow are kept as-is
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (in_valid) begin
                  r_acc  <= w_sum;
                  r_ovfl <= r_ovfl | w_ovfl;
                  r_cnt  <= r_cnt - c_CNT_ONE;
                  if (r_cnt == c_CNT_ONE) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state  <= ST_IDLE;
               r_done   <= 1'b0;
               r_busy   <= 1'b0;
               r_flag_n <= r_acc[15];
               r_flag_z <= (r_acc == 16'h0000);
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign acc_out     = r_acc;
   assign busy        = r_busy;
   assign done        = r_done;
   assign ovfl_sticky = r_ovfl;
   assign flag_n      = r_flag_n;
   assign flag_z      = r_flag_z;
endmodule
`default_nettype wire

// File: tb/tb_sat_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sat_accum_seq
//  Description : Self-checking bench for sat_accum_seq. Directed jobs push
//                their expected results into a scoreboard queue; a monitor
//                pops and compares on every done pulse, then checks flags
//                one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_accum_seq;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  len;
   logic        abort;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_sub;
   logic        in_ready;
   logic [15:0] acc_out;
   logic        busy;
   logic        done;
   logic        ovfl_sticky;
   logic        flag_n;
   logic        flag_z;

   typedef struct {
      logic [15:0] acc;
      logic        ovfl;
      logic        n;
      logic        z;
   } exp_t;

   exp_t q_exp[$];
   int   checks = 0;
   int   errors = 0;

   sat_accum_seq #(.LEN_W(4), .CLEAR_ON_START(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .len         (len),
      .abort       (abort),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_sub      (in_sub),
      .in_ready    (in_ready),
      .acc_out     (acc_out),
      .busy        (busy),
      .done        (done),
      .ovfl_sticky (ovfl_sticky),
      .flag_n      (flag_n),
      .flag_z      (flag_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   exp_t cur;
   bit   flag_pending = 1'b0;

   always @(negedge clk) begin
      if (flag_pending) begin
         flag_pending = 1'b0;
         check("done_one_cycle", {15'd0, done}, 16'd0);
         check("flag_n", {15'd0, flag_n}, {15'd0, cur.n});
         check("flag_z", {15'd0, flag_z}, {15'd0, cur.z});
      end else if (done === 1'b1) begin
         if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
         end else begin
            cur = q_exp.pop_front();
            check("sb_acc", acc_out, cur.acc);
            check("sb_ovfl", {15'd0, ovfl_sticky}, {15'd0, cur.ovfl});
            check("sb_busy", {15'd0, busy}, 16'd1);
            flag_pending = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // All helpers are entered and left at posedge+1.
   task automatic push(input logic [15:0] a, input logic o, input logic n, input logic z);
      exp_t e;
      e.acc = a; e.ovfl = o; e.n = n; e.z = z;
      q_exp.push_back(e);
   endtask

   task automatic start_job(input logic [3:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic op(input logic v, input logic [15:0] d, input logic s);
      in_valid = v;
      in_data  = d;
      in_sub   = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      in_sub   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; in_sub = 1'b0;
      #12;
      check("rst_acc",   acc_out, 16'h0000);
      check("rst_ready", {15'd0, in_ready}, 16'd0);
      check("rst_busy",  {15'd0, busy}, 16'd0);
      check("rst_done",  {15'd0, done}, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // Basic sum: 5 + 7 - 2 = 10
      push(16'h000A, 1'b0, 1'b0, 1'b0);
      start_job(4'd3);
      check("accum_ready", {15'd0, in_ready}, 16'd1);
      op(1'b1, 16'd5, 1'b0);
      op(1'b1, 16'd7, 1'b0);
      op(1'b1, 16'd2, 1'b1);
      check("basic_done_latency", {15'd0, done}, 16'd1);
      idle(3);

      // Positive saturation
      push(16'h7FFF, 1'b1, 1'b0, 1'b0);
      start_job(4'd3);
      op(1'b1, 16'h7000, 1'b0);
      op(1'b1, 16'h2000, 1'b0);
      check("pos_sat_step2", acc_out, 16'h7FFF);
      op(1'b1, 16'h0001, 1'b0);
      idle(3);

      // Negative saturation via subtraction
      push(16'h8000, 1'b1, 1'b1, 1'b0);
      start_job(4'd2);
      op(1'b1, 16'h7FFF, 1'b1);
      check("neg_sat_step1", acc_out, 16'h8001);
      check("neg_sat_ovfl1", {15'd0, ovfl_sticky}, 16'd0);
      op(1'b1, 16'h0002, 1'b1);
      idle(3);

      // Backpressure gaps: valid 1,0,0,1
      push(16'h0007, 1'b0, 1'b0, 1'b0);
      start_job(4'd2);
      op(1'b1, 16'd3, 1'b0);
      op(1'b0, 16'hFFFF, 1'b0);
      op(1'b0, 16'hFFFF, 1'b1);
      check("gap_hold_acc", acc_out, 16'h0003);
      check("gap_no_done", {15'd0, done}, 16'd0);
      op(1'b1, 16'd4, 1'b0);
      check("gap_done_latency", {15'd0, done}, 16'd1);
      idle(3);

      // Abort after two operands
      start_job(4'd4);
      op(1'b1, 16'd1, 1'b0);
      op(1'b1, 16'd2, 1'b0);
      abort = 1'b1; in_valid = 1'b1; in_data = 16'd5;
      #1;
      check("abort_ready", {15'd0, in_ready}, 16'd0);
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      check("abort_acc",  acc_out, 16'h0003);
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_idle_ready", {15'd0, in_ready}, 16'd0);
      idle(3);

      // len = 0: immediate done, accumulator cleared from 3
      push(16'h0000, 1'b0, 1'b0, 1'b1);
      start_job(4'd0);
      check("len0_done", {15'd0, done}, 16'd1);
      idle(3);

      // Reset mid-job
      start_job(4'd4);
      op(1'b1, 16'd9, 1'b0);
      op(1'b1, 16'h8000, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_acc",   acc_out, 16'h0000);
      check("arst_busy",  {15'd0, busy}, 16'd0);
      check("arst_ready", {15'd0, in_ready}, 16'd0);
      check("arst_flags", {13'd0, ovfl_sticky, flag_n, flag_z}, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3);

      // start pulsed during ACCUM is ignored
      push(16'h000B, 1'b0, 1'b0, 1'b0);
      start_job(4'd2);
      op(1'b1, 16'd5, 1'b0);
      start = 1'b1; len = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_accum_acc", acc_out, 16'h0005);
      op(1'b1, 16'd6, 1'b0);
      idle(4);

      check("sb_empty", 16'(q_exp.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
